// File: rtl/muldiv_unit.sv
// Multiply/divide unit owning HI/LO. Results are computed when the op is accepted,
// held in staging registers, and committed when the fixed-latency down-counter expires.
//
// state  | meaning
// S_IDLE | Busy=0, accepts Start (mult/div/mthi/mtlo)
// S_RUN  | Busy=1, counter runs down, staged HI/LO commit on 1->0
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    hi_q, hi_d, lo_q, lo_d;
    logic [31:0]    stg_hi_q, stg_hi_d, stg_lo_q, stg_lo_d;
    logic           stg_wr_q, stg_wr_d;

    logic signed [63:0] a_sx, b_sx, prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] b_safe;
    logic               b_zero, div_ovf;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;

    assign a_sx    = {{32{A[31]}}, A};
    assign b_sx    = {{32{B[31]}}, B};
    assign prod_s  = a_sx * b_sx;
    assign prod_u  = {32'd0, A} * {32'd0, B};
    assign b_zero  = (B == 32'd0);
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    // Divisor forced to 1 on divide-by-zero; the result is discarded anyway.
    assign b_safe  = b_zero ? 32'd1 : B;

    always_comb begin
        quot_s = $signed(A) / $signed(b_safe);
        rem_s  = $signed(A) % $signed(b_safe);
        if (div_ovf) begin
            quot_s = 32'sh8000_0000;
            rem_s  = 32'sd0;
        end
        quot_u = A / b_safe;
        rem_u  = A % b_safe;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        stg_hi_d = stg_hi_q;
        stg_lo_d = stg_lo_q;
        stg_wr_d = stg_wr_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (Op)
                        3'd0: begin
                            stg_hi_d = prod_s[63:32];
                            stg_lo_d = prod_s[31:0];
                            stg_wr_d = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES);
                            state_d  = S_RUN;
                        end
                        3'd1: begin
                            stg_hi_d = prod_u[63:32];
                            stg_lo_d = prod_u[31:0];
                            stg_wr_d = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES);
                            state_d  = S_RUN;
                        end
                        3'd2: begin
                            stg_hi_d = rem_s;
                            stg_lo_d = quot_s;
                            stg_wr_d = !b_zero;
                            cnt_d    = CW'(DIV_CYCLES);
                            state_d  = S_RUN;
                        end
                        3'd3: begin
                            stg_hi_d = rem_u;
                            stg_lo_d = quot_u;
                            stg_wr_d = !b_zero;
                            cnt_d    = CW'(DIV_CYCLES);
                            state_d  = S_RUN;
                        end
                        3'd4:    hi_d = A;
                        3'd5:    lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if (stg_wr_q) begin
                        hi_d = stg_hi_q;
                        lo_d = stg_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            stg_hi_q <= '0;
            stg_lo_q <= '0;
            stg_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            stg_hi_q <= stg_hi_d;
            stg_lo_q <= stg_lo_d;
            stg_wr_q <= stg_wr_d;
        end
    end

    assign Busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results, a monitor
// checks latency, HI/LO hold during RUN, and the committed values.
module tb_muldiv_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Op    = 3'd0;
    logic [31:0] A     = 32'd0;
    logic [31:0] B     = 32'd0;
    logic        Busy;
    logic [31:0] HI, LO;

    always #5 Clk = ~Clk;

    muldiv_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .HI(HI), .LO(LO)
    );

    typedef struct {
        int          lat;
        logic [2:0]  op;
        logic [31:0] old_hi, old_lo, exp_hi, exp_lo;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Architectural reference: plain 64-bit arithmetic on the operands.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t    e;
        longint  sa, sb, q, r, p;
        longint unsigned ua, ub, uq, ur, up;
        e.op = op; e.old_hi = ref_hi; e.old_lo = ref_lo; e.lat = -1;
        case (op)
            3'd0: begin
                sa = $signed(a); sb = $signed(b); p = sa * sb;
                ref_hi = p[63:32]; ref_lo = p[31:0]; e.lat = MULT_N;
            end
            3'd1: begin
                ua = {32'd0, a}; ub = {32'd0, b}; up = ua * ub;
                ref_hi = up[63:32]; ref_lo = up[31:0]; e.lat = MULT_N;
            end
            3'd2: begin
                if (b != 0) begin
                    sa = $signed(a); sb = $signed(b); q = sa / sb; r = sa % sb;
                    ref_hi = r[31:0]; ref_lo = q[31:0];
                end
                e.lat = DIV_N;
            end
            3'd3: begin
                if (b != 0) begin
                    ua = {32'd0, a}; ub = {32'd0, b}; uq = ua / ub; ur = ua % ub;
                    ref_hi = ur[31:0]; ref_lo = uq[31:0];
                end
                e.lat = DIV_N;
            end
            3'd4: begin ref_hi = a; e.lat = 0; end
            3'd5: begin ref_lo = a; e.lat = 0; end
            default: ;
        endcase
        e.exp_hi = ref_hi; e.exp_lo = ref_lo;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the op has completed.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   g;
        Start = 1'b1; Op = op; A = a; B = b;
        e = model(op, a, b);
        if (e.lat >= 0) exp_q.push_back(e);
        @(negedge Clk);
        Start = 1'b0; A = $urandom; B = $urandom;
        g = 0;
        while (Busy && g < 100) begin
            @(negedge Clk);
            g++;
        end
    endtask

    logic busy_neg = 1'b0;
    always @(negedge Clk) busy_neg = Busy;
    always @(posedge Clk)
        if (Reset && Start && busy_neg)
            $display("note: Start while Busy (must be ignored) at %0t", $time);

    // Monitor
    initial begin : monitor
        exp_t        e;
        int          cnt;
        logic [31:0] hold_hi, hold_lo;
        wait (Reset === 1'b1);
        @(negedge Clk);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        forever begin
            @(posedge Clk);
            if (Reset === 1'b1 && Start === 1'b1 && Op <= 3'd5) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_accept: op %0d accepted with nothing expected", Op);
                end else begin
                    e = exp_q.pop_front();
                    if (e.lat == 0) begin
                        @(negedge Clk);
                        chk("mt_busy", {31'd0, Busy}, 32'd0);
                        chk("mt_hi", HI, e.exp_hi);
                        chk("mt_lo", LO, e.exp_lo);
                    end else begin
                        cnt = 0; hold_hi = e.old_hi; hold_lo = e.old_lo;
                        forever begin
                            @(negedge Clk or negedge Reset);
                            if (!Reset) begin
                                #1;
                                chk("abort_busy", {31'd0, Busy}, 32'd0);
                                chk("abort_hi", HI, 32'd0);
                                chk("abort_lo", LO, 32'd0);
                                wait (Reset === 1'b1);
                                break;
                            end
                            if (Busy) begin
                                cnt++;
                                if (HI !== e.old_hi) hold_hi = HI;
                                if (LO !== e.old_lo) hold_lo = LO;
                                if (cnt > e.lat + 20) begin
                                    n_cmp++; n_err++;
                                    $display("FAIL busy_timeout: busy %0d cycles, expected %0d", cnt, e.lat);
                                    break;
                                end
                            end else begin
                                chk("busy_cycles", 32'(cnt), 32'(e.lat));
                                chk("hold_hi", hold_hi, e.old_hi);
                                chk("hold_lo", hold_lo, e.old_lo);
                                chk("commit_hi", HI, e.exp_hi);
                                chk("commit_lo", LO, e.exp_lo);
                                break;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Stimulus
    initial begin : stim
        exp_t        e;
        int          g;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          sel;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        issue(3'd4, 32'h1234_5678, 32'd0);
        issue(3'd2, 32'h0000_0055, 32'd0);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd5, 32'hCAFE_BABE, 32'd0);
        issue(3'd6, 32'h1111_1111, 32'h2222_2222);

        // Start pulse during a DIV must be ignored
        Start = 1'b1; Op = 3'd2; A = 32'd1000; B = 32'hFFFF_FFF9;
        e = model(3'd2, 32'd1000, 32'hFFFF_FFF9);
        exp_q.push_back(e);
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        Start = 1'b1; Op = 3'd0; A = 32'd5; B = 32'd7;
        @(negedge Clk);
        Start = 1'b0;
        g = 0;
        while (Busy && g < 100) begin @(negedge Clk); g++; end

        // Asynchronous reset mid-DIV aborts the op
        Start = 1'b1; Op = 3'd2; A = 32'd12345; B = 32'd7;
        e = model(3'd2, 32'd12345, 32'd7);
        exp_q.push_back(e);
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b0;
        ref_hi = 32'd0; ref_lo = 32'd0;
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        repeat (12) @(negedge Clk);
        issue(3'd0, 32'd6, 32'd7);

        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 16));
            issue(op, a, b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
        end

        repeat (5) @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
